// File: rtl/fa_dataflow_pkg.sv
// Shared definitions for the adders library leaf cell.
// FA_TT_W is the width of the full-adder truth-table index {a, b, cin}.
// FA_TT_DEPTH is the number of entries in that table.
package fa_dataflow_pkg;

    localparam int FA_TT_W     = 3;
    localparam int FA_TT_DEPTH = 1 << FA_TT_W;

endpackage

// File: rtl/fa_dataflow_bit.sv
// fa_bit: pure combinational 1-bit full adder, dataflow equations only.
// Ports:
//   a, b  - addend bits
//   cin   - carry in
//   s     - sum, a ^ b ^ cin
//   cout  - carry out, majority of a, b and cin
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;

    // p is the propagate term. It is shared by the sum and the carry equations.
    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/fa_dataflow.sv
// fa_dataflow: a 1-bit full adder with combinational s/cout outputs and an
// optional registered output stage that has a capture enable.
// Ports:
//   clk     - rising-edge clock for the registered stage
//   rst     - synchronous, active-high reset; it has priority over en
//   a, b    - addend bits
//   cin     - carry in
//   en      - capture enable for the registered stage
//   s       - combinational sum
//   cout    - combinational carry out
//   s_q     - registered sum; holds its value while en is low
//   cout_q  - registered carry out; holds its value while en is low
//   vld_q   - high for exactly the cycle after a capture
// Parameter:
//   REG_OUT - 1 builds the register stage; 0 ties s_q/cout_q/vld_q to 0
module fa_dataflow
    import fa_dataflow_pkg::*;
#(
    parameter bit REG_OUT = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic en,
    output logic s,
    output logic cout,
    output logic s_q,
    output logic cout_q,
    output logic vld_q
);

    fa_bit u_fa_bit (
        .a    (a),
        .b    (b),
        .cin  (cin),
        .s    (s),
        .cout (cout)
    );

    generate
        if (REG_OUT) begin : g_reg
            logic s_d;
            logic cout_d;
            logic vld_d;

            always_comb begin
                s_d    = s_q;
                cout_d = cout_q;
                vld_d  = 1'b0;
                if (en) begin
                    s_d    = s;
                    cout_d = cout;
                    vld_d  = 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    s_q    <= 1'b0;
                    cout_q <= 1'b0;
                    vld_q  <= 1'b0;
                end else begin
                    s_q    <= s_d;
                    cout_q <= cout_d;
                    vld_q  <= vld_d;
                end
            end
        end else begin : g_noreg
            // clk, rst and en have no function in this build.
            logic unused_ctl;
            assign unused_ctl = ^{clk, rst, en};

            assign s_q    = 1'b0;
            assign cout_q = 1'b0;
            assign vld_q  = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_fa_dataflow.sv
module tb_fa_dataflow;
    import fa_dataflow_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic a = 1'b0, b = 1'b0, cin = 1'b0, en = 1'b0;

    logic s1, c1, sq1, cq1, vq1;
    logic s0, c0, sq0, cq0, vq0;

    always #5 clk = ~clk;

    fa_dataflow #(.REG_OUT(1'b1)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .en(en),
        .s(s1), .cout(c1), .s_q(sq1), .cout_q(cq1), .vld_q(vq1)
    );

    fa_dataflow #(.REG_OUT(1'b0)) dut0 (
        .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .en(en),
        .s(s0), .cout(c0), .s_q(sq0), .cout_q(cq0), .vld_q(vq0)
    );

    typedef struct {
        logic [FA_TT_W-1:0] abc;
        logic [1:0]         cs;   // {cout, s}
    } vec_t;

    vec_t tt[FA_TT_DEPTH];

    int n_vec = 0;
    int n_err = 0;

    // The expected registered {cout_q, s_q, vld_q} is pushed when a cycle is driven.
    // It is popped after the capturing edge.
    logic [2:0] sb_q[$];
    logic m_s = 1'b0, m_c = 1'b0, m_v = 1'b0;

    task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input logic [2:0] abc_v, input logic en_v, input logic rst_v);
        logic [2:0] exp;
        @(negedge clk);
        {a, b, cin} = abc_v;
        en  = en_v;
        rst = rst_v;
        if (rst_v) begin
            m_s = 1'b0; m_c = 1'b0; m_v = 1'b0;
        end else if (en_v) begin
            {m_c, m_s} = tt[abc_v].cs;
            m_v = 1'b1;
        end else begin
            m_v = 1'b0;
        end
        sb_q.push_back({m_c, m_s, m_v});
        #1;
        chk("comb_reg1", {1'b0, c1, s1}, {1'b0, tt[abc_v].cs});
        chk("comb_reg0", {1'b0, c0, s0}, {1'b0, tt[abc_v].cs});
        @(posedge clk);
        #1;
        exp = sb_q.pop_front();
        chk("reg_stage", {cq1, sq1, vq1}, exp);
        chk("noreg_zero", {cq0, sq0, vq0}, 3'b000);
    endtask

    initial begin
        tt[0] = '{3'd0, 2'b00};
        tt[1] = '{3'd1, 2'b01};
        tt[2] = '{3'd2, 2'b01};
        tt[3] = '{3'd3, 2'b10};
        tt[4] = '{3'd4, 2'b01};
        tt[5] = '{3'd5, 2'b10};
        tt[6] = '{3'd6, 2'b10};
        tt[7] = '{3'd7, 2'b11};

        // Exhaustive sweep with the stage held in reset.
        for (int i = 0; i < FA_TT_DEPTH; i++)
            cycle(tt[i].abc, 1'b0, 1'b1);

        // Capture 101 -> s_q=0, cout_q=1, vld_q=1.
        cycle(3'b101, 1'b1, 1'b0);
        chk("capture_101", {cq1, sq1, vq1}, 3'b101);

        // Capture 111, then hold for 3 cycles with the inputs at 000.
        cycle(3'b111, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(3'b000, 1'b0, 1'b0);
            chk("hold", {cq1, sq1, vq1}, 3'b110);
            chk("hold_comb", {1'b0, c1, s1}, 3'b000);
        end

        // Reset wins over enable; the combinational outputs are not affected.
        cycle(3'b111, 1'b1, 1'b1);
        chk("rst_prio", {cq1, sq1, vq1}, 3'b000);
        chk("rst_prio_comb", {1'b0, c1, s1}, 3'b011);

        // Back-to-back streaming through the truth table.
        for (int i = 0; i < FA_TT_DEPTH; i++)
            cycle(tt[i].abc, 1'b1, 1'b0);

        // Enable drops once, then one more capture after it.
        cycle(3'b011, 1'b0, 1'b0);
        cycle(3'b110, 1'b1, 1'b0);

        // Random control activity. The REG_OUT=0 build must keep its registered outputs at 0.
        for (int i = 0; i < 16; i++)
            cycle(3'($urandom_range(7)), 1'($urandom_range(1)),
                  ($urandom_range(7) == 0) ? 1'b1 : 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
